dma_controller: RTL

- Bus-master DMA engine on the other end of the external device link: sole driver of the device `offset` input and consumer of its 4-word `data` output.
- CPU programs a transfer after the device interrupt. The block then requests the memory bus with BR/BG, reads 64-bit blocks from the device, and writes them to memory.
- Signals completion to the CPU with a one-cycle `dma_end` pulse.

---
 rtl/dma_controller.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dma_controller.sv
// dma_controller: bus-master DMA engine that copies 4-word blocks from the
// external device into memory once the CPU has granted the bus.
//
// Handshake: a command is taken on any cycle where cmd_valid=1 and the engine
// is idle; there is no ready signal, so commands arriving while busy are
// dropped silently. br/bg is a level handshake: br stays high for the whole
// transfer, and memory writes only advance on cycles where bg=1.
module dma_controller #(
  parameter int WORD_SIZE      = 16,
  parameter int DEVICE_BIT_LEN = 2,
  parameter int MAX_BLOCKS     = 3,
  parameter int WRITE_LATENCY  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  input  logic [WORD_SIZE-1:0]   cmd_addr,
  input  logic [WORD_SIZE-1:0]   cmd_length,
  output logic                   cmd_err,
  output logic                   br,
  input  logic                   bg,
  output logic [DEVICE_BIT_LEN-1:0] offset,
  input  logic [4*WORD_SIZE-1:0] dev_data,
  output logic [WORD_SIZE-1:0]   mem_addr,
  output logic [4*WORD_SIZE-1:0] mem_wdata,
  output logic                   mem_write,
  output logic                   dma_end,
  output logic [2:0]             dbg_state
);

  localparam int CW = $clog2(MAX_BLOCKS + 1);
  localparam int LW = $clog2(WRITE_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_SETUP   = 3'd2,
    S_CAPTURE = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t               state;
  logic [WORD_SIZE-1:0] base;
  logic [CW-1:0]        nblocks;
  logic [CW-1:0]        blk_cnt;
  logic [CW-1:0]        blk_next;
  logic [LW-1:0]        lat_cnt;
  logic                 cmd_ok;
  logic                 last_wr;

  // Length must be a whole number of blocks and fit in the device.
  assign cmd_ok = (cmd_length[1:0] == 2'b00) &&
                  (cmd_length >= WORD_SIZE'(4)) &&
                  (cmd_length <= WORD_SIZE'(4 * MAX_BLOCKS));

  assign blk_next = blk_cnt + CW'(1);
  assign last_wr  = bg && (lat_cnt == LW'(WRITE_LATENCY - 1));

  // Write strobe drops in the same cycle bg is withdrawn, so it is gated
  // combinationally rather than registered.
  assign mem_write = (state == S_WRITE) && bg;
  assign dbg_state = state;

  // Transfer sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      base      <= '0;
      nblocks   <= '0;
      blk_cnt   <= '0;
      lat_cnt   <= '0;
      br        <= 1'b0;
      offset    <= '1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cmd_err   <= 1'b0;
      dma_end   <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      dma_end <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_ok) begin
              base    <= cmd_addr;
              nblocks <= CW'(cmd_length >> 2);
              blk_cnt <= '0;
              br      <= 1'b1;
              state   <= S_REQ;
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (bg) begin
            offset <= DEVICE_BIT_LEN'(blk_cnt);
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          // Device data is combinational from offset; give it one cycle.
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          mem_wdata <= dev_data;
          mem_addr  <= base + (WORD_SIZE'(blk_cnt) << 2);
          lat_cnt   <= '0;
          state     <= S_WRITE;
        end
        S_WRITE: begin
          if (bg) begin
            if (last_wr) begin
              blk_cnt <= blk_next;
              if (blk_next == nblocks) begin
                br      <= 1'b0;
                offset  <= '1;
                dma_end <= 1'b1;
                state   <= S_DONE;
              end else begin
                offset <= DEVICE_BIT_LEN'(blk_next);
                state  <= S_SETUP;
              end
            end else begin
              lat_cnt <= lat_cnt + LW'(1);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
